// File: rtl/ps2_host_controller.sv
// rtl/ps2_host_controller.sv - PS/2 host port: filtered line sampling, device frame receive, host command send with retries
`timescale 1ns/1ps
module ps2_host_controller #(
  parameter int FILTER_LEN     = 4,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_TRIES      = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_ERR,
  input  logic [7:0] TX_DATA,
  input  logic       TX_REQ,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {IDLE, RX, TX_INH, TX_RTS, TX_SHIFT, TX_ACK} state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          clk_filt_q, clk_filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_q, fall_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [RW-1:0] tries_q, tries_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          timed_out, fail;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_byte_q  <= '0;
      tries_q    <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_byte_q  <= tx_byte_d;
      tries_q    <= tries_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_s1_d   = PS2_CLK_IN;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = PS2_DATA_IN;
    dat_s2_d   = dat_s1_q;
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_byte_d  = tx_byte_q;
    tries_d    = tries_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    timed_out  = 1'b0;
    fail       = 1'b0;

    // Filtered clock flips only after FILTER_LEN consecutive differing samples
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
    fall_d = clk_filt_q & ~clk_filt_d;

    if (state_q == IDLE || state_q == TX_INH || fall_q) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      timed_out = 1'b1;
      to_cnt_d  = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (fall_q && !dat_s2_q) begin
          state_d   = RX;
          bit_cnt_d = 4'd1;
        end else if (TX_REQ) begin
          state_d   = TX_INH;
          tx_byte_d = TX_DATA;
          tries_d   = RW'(1);
          busy_d    = 1'b1;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
        end
      end
      RX: begin
        if (timed_out) begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end else if (fall_q) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd9) begin
            shift_d = {dat_s2_q, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
            par_d = dat_s2_q;
          end else begin
            if (^{shift_q, par_q} && dat_s2_q) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
            state_d = IDLE;
          end
        end
      end
      TX_INH: begin
        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = TX_RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + IW'(1);
        end
      end
      TX_RTS: begin
        if (timed_out) begin
          fail = 1'b1;
        end else if (fall_q) begin
          data_oe_d = ~tx_byte_q[0];
          bit_cnt_d = 4'd1;
          state_d   = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (timed_out) begin
          fail = 1'b1;
        end else if (fall_q) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~tx_byte_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            // odd parity bit is ~^byte; pulling low means the bit is 0
            data_oe_d = ^tx_byte_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = TX_ACK;
          end
        end
      end
      TX_ACK: begin
        if (timed_out) begin
          fail = 1'b1;
        end else if (fall_q) begin
          if (!dat_s2_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
      data_oe_d = 1'b0;
      clk_oe_d  = 1'b0;
      if (tries_q < RW'(MAX_TRIES)) begin
        tries_d   = tries_q + RW'(1);
        inh_cnt_d = '0;
        clk_oe_d  = 1'b1;
        state_d   = TX_INH;
      end else begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  assign PS2_CLK_OE  = clk_oe_q;
  assign PS2_DATA_OE = data_oe_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign RX_ERR      = rx_err_q;
  assign TX_BUSY     = busy_q;
  assign TX_DONE     = done_q;
  assign TX_ERR      = err_q;

endmodule

// File: tb/tb_ps2_host_controller.sv
// tb/tb_ps2_host_controller.sv - directed bench with open-drain PS/2 device model and event scoreboard
`timescale 1ns/1ps
module tb_ps2_host_controller;

  localparam int FL   = 4;
  localparam int INH  = 50;
  localparam int TO   = 300;
  localparam int TRY  = 3;
  localparam int HP   = 20;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  data;
    logic [31:0] cyc;
  } ev_t;

  localparam logic [1:0] K_RXV = 2'd0, K_RXE = 2'd1, K_TXD = 2'd2, K_TXE = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_oe, data_oe, rx_valid, rx_err, tx_busy, tx_done, tx_err;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
  assign ps2_data_line = ~(data_oe | dev_data_low);

  ps2_host_controller #(
    .FILTER_LEN(FL), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .MAX_TRIES(TRY)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .PS2_CLK_IN(ps2_clk_line), .PS2_DATA_IN(ps2_data_line),
    .PS2_CLK_OE(clk_oe), .PS2_DATA_OE(data_oe), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .RX_ERR(rx_err), .TX_DATA(tx_data), .TX_REQ(tx_req), .TX_BUSY(tx_busy),
    .TX_DONE(tx_done), .TX_ERR(tx_err)
  );

  always #5 clk = ~clk;

  int  checks = 0, failures = 0;
  int  cyc = 0, excl_viol = 0, run_len = 0, last_inh_len = 0, inh_pulses = 0;
  int  obs_rd = 0, last_fall_cyc = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) obs_q.push_back('{K_RXV, rx_data, cyc});
    if (rx_err)   obs_q.push_back('{K_RXE, 8'h00, cyc});
    if (tx_done)  obs_q.push_back('{K_TXD, 8'h00, cyc});
    if (tx_err)   obs_q.push_back('{K_TXE, 8'h00, cyc});
    if ((rx_valid && rx_err) || (tx_done && tx_err) || (clk_oe && data_oe)) excl_viol++;
    if (clk_oe) run_len++;
    else if (run_len != 0) begin
      last_inh_len = run_len;
      inh_pulses++;
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [7:0] d);
    exp_q.push_back('{k, d, 32'd0});
  endtask

  task automatic drain();
    ev_t o, e;
    while (obs_rd < obs_q.size()) begin
      o = obs_q[obs_rd];
      obs_rd++;
      if (exp_q.size() == 0) begin
        chk("sb_extra_event", {30'd0, o.kind}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_kind", {30'd0, o.kind}, {30'd0, e.kind});
        if (e.kind == K_RXV) chk("sb_rx_data", {24'd0, o.data}, {24'd0, e.data});
      end
    end
    chk("sb_pending", exp_q.size(), 0);
  endtask

  task automatic wait_busy(input logic val);
    int n = 0;
    while (tx_busy !== val && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_busy_wait", {31'd0, tx_busy}, {31'd0, val});
  endtask

  task automatic dev_send(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_data_low = ~fr[i];
      repeat (HP) @(posedge clk);
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (HP) @(posedge clk);
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
    repeat (HP) @(posedge clk);
  endtask

  task automatic dev_recv(output logic [7:0] b, output logic p, output logic s, input logic ack);
    logic [9:0] got;
    int n = 0;
    got = '0;
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rts_seen", {30'd0, ps2_clk_line, ps2_data_line}, 32'd2);
    repeat (HP) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HP) @(posedge clk);
      got[k] = ps2_data_line;
      dev_clk_low = 1'b0;
      repeat (HP) @(posedge clk);
    end
    if (ack) dev_data_low = 1'b1;
    dev_clk_low = 1'b1;
    repeat (HP) @(posedge clk);
    dev_clk_low = 1'b0;
    repeat (HP) @(posedge clk);
    dev_data_low = 1'b0;
    b = got[7:0];
    p = got[8];
    s = got[9];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    logic       rp, rs;
    int         inh0, lat;

    repeat (3) @(negedge clk);
    chk("rst_clk_oe", {31'd0, clk_oe}, 0);
    chk("rst_data_oe", {31'd0, data_oe}, 0);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_pulses", {28'd0, rx_valid, rx_err, tx_done, tx_err}, 0);
    chk("rst_busy", {31'd0, tx_busy}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // good frame
    expect_ev(K_RXV, 8'h1C);
    dev_send(8'h1C, 1'b0, 11);
    drain();
    chk("rx_data_1c", {24'd0, rx_data}, 32'h1C);

    // parity errors keep the previous byte
    expect_ev(K_RXE, 8'h00);
    dev_send(8'h1C, 1'b1, 11);
    expect_ev(K_RXE, 8'h00);
    dev_send(8'h3C, 1'b1, 11);
    drain();
    chk("rx_data_kept", {24'd0, rx_data}, 32'h1C);

    // LED command with device ACK, then device response byte
    tx_data = 8'hED;
    tx_req  = 1'b1;
    expect_ev(K_TXD, 8'h00);
    wait_busy(1'b1);
    tx_req  = 1'b0;
    tx_data = 8'h00;
    dev_recv(rb, rp, rs, 1'b1);
    chk("tx_byte_ed", {24'd0, rb}, 32'hED);
    chk("tx_parity_ed", {31'd0, rp}, 1);
    chk("tx_stop_ed", {31'd0, rs}, 1);
    chk("inhibit_len", last_inh_len, INH);
    wait_busy(1'b0);
    expect_ev(K_RXV, 8'hFA);
    dev_send(8'hFA, 1'b0, 11);
    drain();

    // device never ACKs: all attempts fail
    inh0    = inh_pulses;
    tx_data = 8'h5A;
    tx_req  = 1'b1;
    expect_ev(K_TXE, 8'h00);
    wait_busy(1'b1);
    tx_req = 1'b0;
    for (int a = 0; a < TRY; a++) begin
      dev_recv(rb, rp, rs, 1'b0);
      chk("retry_byte", {24'd0, rb}, 32'h5A);
    end
    wait_busy(1'b0);
    repeat (5) @(negedge clk);
    chk("inhibit_pulses", inh_pulses - inh0, TRY);
    chk("inhibit_len_retry", last_inh_len, INH);
    drain();

    // device stalls mid-frame, then a good frame
    expect_ev(K_RXE, 8'h00);
    dev_send(8'h2A, 1'b0, 5);
    repeat (TO + 60) @(negedge clk);
    lat = (obs_rd < obs_q.size()) ? int'(obs_q[obs_rd].cyc) - last_fall_cyc : -1;
    checks++;
    assert (lat >= TO && lat <= TO + 20) else begin
      failures++;
      $error("FAIL rx_timeout_latency observed=%0d expected=%0d..%0d", lat, TO, TO + 20);
    end
    expect_ev(K_RXV, 8'h2A);
    dev_send(8'h2A, 1'b0, 11);
    drain();

    // TX request lands on the RX start-bit fall strobe: RX first
    expect_ev(K_RXV, 8'h77);
    expect_ev(K_TXD, 8'h00);
    fork
      dev_send(8'h77, 1'b0, 11);
      begin
        repeat (HP + 6) @(posedge clk);
        tx_data = 8'hF4;
        tx_req  = 1'b1;
      end
    join
    wait_busy(1'b1);
    tx_req = 1'b0;
    dev_recv(rb, rp, rs, 1'b1);
    chk("tx_byte_f4", {24'd0, rb}, 32'hF4);
    wait_busy(1'b0);
    drain();

    // reset during a transmit releases both lines at once
    tx_data = 8'hAB;
    tx_req  = 1'b1;
    wait_busy(1'b1);
    tx_req = 1'b0;
    begin
      int n = 0;
      while (data_oe !== 1'b1 && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rts_before_reset", {31'd0, data_oe}, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_oe", {30'd0, clk_oe, data_oe}, 0);
    chk("async_rst_busy", {31'd0, tx_busy}, 0);
    chk("async_rst_rx_data", {24'd0, rx_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    drain();
    chk("exclusivity", excl_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
